// File: rtl/hazard_pkg.sv
// Shared RV32 opcode constants and instruction field helpers for the ID-stage hazard logic.
package hazard_pkg;

   localparam logic [6:0] LOAD    = 7'b0000011;
   localparam logic [6:0] STORE   = 7'b0100011;
   localparam logic [6:0] BRANCH  = 7'b1100011;
   localparam logic [6:0] JAL     = 7'b1101111;
   localparam logic [6:0] JALR    = 7'b1100111;
   localparam logic [6:0] OP      = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] CUSTOM0 = 7'b0001011;
   localparam logic [6:0] LUI     = 7'b0110111;
   localparam logic [6:0] AUIPC   = 7'b0010111;

   typedef struct packed {
      logic use_rs1;
      logic use_rs2;
      logic is_load;
   } src_use_t;

   function automatic logic [4:0] rd_of(input logic [31:0] inst);
      return inst[11:7];
   endfunction

   function automatic logic [4:0] rs1_of(input logic [31:0] inst);
      return inst[19:15];
   endfunction

   function automatic logic [4:0] rs2_of(input logic [31:0] inst);
      return inst[24:20];
   endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// ID-stage handshake between the front end (master) and the load-use scoreboard (slave).
interface load_use_scoreboard_if;
   logic [31:0] ID_Inst;
   logic        ID_valid;
   logic        ID_flush;
   logic        MEM_freeze;
   logic        data_hazard_check;
   logic        ID_issue;

   modport master (
      output ID_Inst, ID_valid, ID_flush, MEM_freeze,
      input  data_hazard_check, ID_issue
   );

   modport slave (
      input  ID_Inst, ID_valid, ID_flush, MEM_freeze,
      output data_hazard_check, ID_issue
   );
endinterface

// File: rtl/hazard_src_decode.sv
// Opcode decode: which source registers an instruction reads and whether it is a load.
module hazard_src_decode
   import hazard_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic       use_rs1_o,
   output logic       use_rs2_o,
   output logic       is_load_o
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch is inferred.
      use_rs1_o = 1'b0;
      use_rs2_o = 1'b0;
      is_load_o = 1'b0;
      case (opcode_i)
         LOAD: begin
            use_rs1_o = 1'b1;
            is_load_o = 1'b1;
         end
         JALR, OP_IMM: use_rs1_o = 1'b1;
         BRANCH, STORE, OP, CUSTOM0: begin
            use_rs1_o = 1'b1;
            use_rs2_o = 1'b1;
         end
         JAL, LUI, AUIPC: begin
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use scoreboard: per-register countdown from load issue, stalls dependent ID instructions.
// Optional stall counter output enabled by macro LOAD_USE_SCOREBOARD_PERF_EN.
module load_use_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int LOAD_LAT = 1
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic [31:0]         ID_Inst,
   input  logic                ID_valid,
   input  logic                ID_flush,
   input  logic                MEM_freeze,
   output logic                data_hazard_check,
   output logic                ID_issue,
   output logic [NUM_REGS-1:0] pending_mask
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]         stall_cycles
`endif
);

   localparam int CW = $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(LOAD_LAT);

   src_use_t    dec;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] pend_ext;
   logic        load_fire;
   logic        unused_inst_bits;

   logic [CW-1:0] cnt_q [NUM_REGS];
   logic [CW-1:0] cnt_d [NUM_REGS];

   hazard_src_decode u_dec (
      .opcode_i  (ID_Inst[6:0]),
      .use_rs1_o (dec.use_rs1),
      .use_rs2_o (dec.use_rs2),
      .is_load_o (dec.is_load)
   );

   assign rd  = rd_of(ID_Inst);
   assign rs1 = rs1_of(ID_Inst);
   assign rs2 = rs2_of(ID_Inst);
   assign unused_inst_bits = ^{ID_Inst[31:25], ID_Inst[14:12]};

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_mask[r] = (cnt_q[r] != '0);
      end
   end

   // Indices at or above NUM_REGS land on the zero-extended bits, so they never stall.
   assign pend_ext = 32'(pending_mask);

   assign data_hazard_check = ID_valid & ~ID_flush &
                              ((dec.use_rs1 & pend_ext[rs1]) | (dec.use_rs2 & pend_ext[rs2]));
   assign ID_issue  = ID_valid & ~ID_flush & ~data_hazard_check & ~MEM_freeze;
   assign load_fire = ID_issue & dec.is_load & (rd != 5'd0);

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!MEM_freeze && cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
         if (load_fire && rd == 5'(r)) cnt_d[r] = LAT_C;
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         // NOTE: this array is live control state, not storage, so every entry is reset.
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         // NOTE: non-blocking so all countdowns update together from pre-edge values.
         cnt_q <= cnt_d;
      end
   end

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (data_hazard_check && stall_q != '1) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Randomised + directed bench for load_use_scoreboard across several LOAD_LAT/NUM_REGS builds.
module tb_load_use_scoreboard;

   localparam int ND = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_use_scoreboard_if bus ();

   logic        haz1, haz2, haz3, iss1, iss2, iss3;
   logic [31:0] m0, m1, m2;
   logic [15:0] m3;
   logic        haz_w [ND];
   logic        iss_w [ND];
   logic [31:0] mask_w [ND];

   assign haz_w[0] = bus.data_hazard_check;
   assign haz_w[1] = haz1;
   assign haz_w[2] = haz2;
   assign haz_w[3] = haz3;
   assign iss_w[0] = bus.ID_issue;
   assign iss_w[1] = iss1;
   assign iss_w[2] = iss2;
   assign iss_w[3] = iss3;
   assign mask_w[0] = m0;
   assign mask_w[1] = m1;
   assign mask_w[2] = m2;
   assign mask_w[3] = {16'h0000, m3};

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
   logic [31:0] sc0, sc1, sc2, sc3;
`endif

   load_use_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1)) dut0 (
      .CLK(clk), .RSTn(rst_n), .ID_Inst(bus.ID_Inst), .ID_valid(bus.ID_valid),
      .ID_flush(bus.ID_flush), .MEM_freeze(bus.MEM_freeze),
      .data_hazard_check(bus.data_hazard_check), .ID_issue(bus.ID_issue), .pending_mask(m0)
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
      , .stall_cycles(sc0)
`endif
   );

   load_use_scoreboard #(.NUM_REGS(32), .LOAD_LAT(2)) dut1 (
      .CLK(clk), .RSTn(rst_n), .ID_Inst(bus.ID_Inst), .ID_valid(bus.ID_valid),
      .ID_flush(bus.ID_flush), .MEM_freeze(bus.MEM_freeze),
      .data_hazard_check(haz1), .ID_issue(iss1), .pending_mask(m1)
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
      , .stall_cycles(sc1)
`endif
   );

   load_use_scoreboard #(.NUM_REGS(32), .LOAD_LAT(3)) dut2 (
      .CLK(clk), .RSTn(rst_n), .ID_Inst(bus.ID_Inst), .ID_valid(bus.ID_valid),
      .ID_flush(bus.ID_flush), .MEM_freeze(bus.MEM_freeze),
      .data_hazard_check(haz2), .ID_issue(iss2), .pending_mask(m2)
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
      , .stall_cycles(sc2)
`endif
   );

   load_use_scoreboard #(.NUM_REGS(16), .LOAD_LAT(2)) dut3 (
      .CLK(clk), .RSTn(rst_n), .ID_Inst(bus.ID_Inst), .ID_valid(bus.ID_valid),
      .ID_flush(bus.ID_flush), .MEM_freeze(bus.MEM_freeze),
      .data_hazard_check(haz3), .ID_issue(iss3), .pending_mask(m3)
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
      , .stall_cycles(sc3)
`endif
   );

   // Reference model: remaining cycles until each register's load data is usable.
   int lat_m [ND] = '{1, 2, 3, 2};
   int nr_m  [ND] = '{32, 32, 32, 16};
   int cd [ND][32];
   int stall_m [ND];
   int n_total = 0;
   int n_bad = 0;

   logic [31:0] cur_inst;
   logic        cur_v, cur_f, cur_fz;
   logic        obs_haz [ND];
   logic        obs_iss [ND];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void decode(input logic [31:0] inst, output bit u1, output bit u2, output bit ld);
      u1 = 0; u2 = 0; ld = 0;
      case (inst[6:0])
         7'h03: begin u1 = 1; ld = 1; end
         7'h67, 7'h13: u1 = 1;
         7'h63, 7'h23, 7'h33, 7'h0b: begin u1 = 1; u2 = 1; end
         default: ;
      endcase
   endfunction

   function automatic bit busy(input int k, input int r);
      return r != 0 && r < nr_m[k] && cd[k][r] > 0;
   endfunction

   function automatic bit m_haz(input int k);
      bit u1, u2, ld;
      decode(cur_inst, u1, u2, ld);
      return cur_v && !cur_f &&
             ((u1 && busy(k, int'(cur_inst[19:15]))) || (u2 && busy(k, int'(cur_inst[24:20]))));
   endfunction

   function automatic logic [31:0] m_mask(input int k);
      logic [31:0] m = '0;
      for (int r = 0; r < 32; r++) if (busy(k, r)) m[r] = 1'b1;
      return m;
   endfunction

   function automatic void model_edge();
      for (int k = 0; k < ND; k++) begin
         bit u1, u2, ld, h, iss;
         int rd;
         decode(cur_inst, u1, u2, ld);
         h   = m_haz(k);
         iss = cur_v && !cur_f && !h && !cur_fz;
         rd  = int'(cur_inst[11:7]);
         if (h) stall_m[k]++;
         if (!cur_fz) for (int r = 0; r < 32; r++) if (cd[k][r] > 0) cd[k][r]--;
         if (iss && ld && rd != 0 && rd < nr_m[k]) cd[k][rd] = lat_m[k];
      end
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < ND; k++) begin
         stall_m[k] = 0;
         for (int r = 0; r < 32; r++) cd[k][r] = 0;
      end
   endfunction

   // Called just after a rising edge; presents one ID cycle and checks every build.
   task automatic step(input logic [31:0] inst, input logic v, input logic f, input logic fz);
      cur_inst = inst; cur_v = v; cur_f = f; cur_fz = fz;
      bus.ID_Inst = inst; bus.ID_valid = v; bus.ID_flush = f; bus.MEM_freeze = fz;
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         bit h;
         h = m_haz(k);
         obs_haz[k] = haz_w[k];
         obs_iss[k] = iss_w[k];
         check($sformatf("haz%0d", k), {31'b0, haz_w[k]}, {31'b0, h});
         check($sformatf("issue%0d", k), {31'b0, iss_w[k]}, {31'b0, cur_v & ~cur_f & ~h & ~cur_fz});
         check($sformatf("mask%0d", k), mask_w[k], m_mask(k));
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run_until_issue(input int k, input logic [31:0] inst, input int n_frz, output int stalls);
      bit done = 0;
      stalls = 0;
      for (int c = 0; c < 40; c++) begin
         step(inst, 1'b1, 1'b0, c < n_frz);
         if (obs_iss[k]) begin
            done = 1;
            break;
         end
         if (obs_haz[k]) stalls++;
      end
      check($sformatf("issue_timeout%0d", k), {31'b0, done}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.ID_valid = 1'b0; bus.ID_flush = 1'b0; bus.MEM_freeze = 1'b0; bus.ID_Inst = '0;
      #1;
      for (int k = 0; k < ND; k++) begin
         check($sformatf("rst_mask%0d", k), mask_w[k], 32'h0);
         check($sformatf("rst_haz%0d", k), {31'b0, haz_w[k]}, 32'h0);
         check($sformatf("rst_issue%0d", k), {31'b0, iss_w[k]}, 32'h0);
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (6) step(32'h0, 1'b0, 1'b0, 1'b0);
   endtask

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
   task automatic check_perf();
      check("perf0", sc0, 32'(stall_m[0]));
      check("perf1", sc1, 32'(stall_m[1]));
      check("perf2", sc2, 32'(stall_m[2]));
      check("perf3", sc3, 32'(stall_m[3]));
   endtask
`endif

   function automatic logic [31:0] lw(input int rd, input int rs1);
      return {12'h000, 5'(rs1), 3'b010, 5'(rd), 7'h03};
   endfunction

   function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
      return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] beq(input int rs1, input int rs2);
      return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'h00, 7'h63};
   endfunction

   localparam logic [31:0] JAL_X1_ALIAS5 = 32'h000280EF;
   localparam logic [31:0] LUI_X5_ALIAS5 = 32'h000282B7;

   initial begin
      int s;
      logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33, 7'h13, 7'h0b, 7'h37, 7'h17};

      do_reset();

      // Dependent add right behind a load, latency 1.
      step(lw(5, 2), 1'b1, 1'b0, 1'b0);
      run_until_issue(0, add(6, 5, 1), 0, s);
      check("lat1_dep_stalls", s, 32'd1);

      // Branch on a latency-3 load, with and without a frozen back end.
      drain();
      step(lw(7, 2), 1'b1, 1'b0, 1'b0);
      run_until_issue(2, beq(7, 0), 0, s);
      check("lat3_dep_stalls", s, 32'd3);
      drain();
      step(lw(7, 2), 1'b1, 1'b0, 1'b0);
      run_until_issue(2, beq(7, 0), 2, s);
      check("lat3_freeze_stalls", s, 32'd5);

      // No stall for x0 destinations or instructions without sources.
      drain();
      step(lw(0, 2), 1'b1, 1'b0, 1'b0);
      run_until_issue(0, add(1, 0, 0), 0, s);
      check("x0_no_stall", s, 32'd0);
      step(lw(5, 2), 1'b1, 1'b0, 1'b0);
      run_until_issue(0, JAL_X1_ALIAS5, 0, s);
      check("jal_no_stall", s, 32'd0);
      step(lw(5, 2), 1'b1, 1'b0, 1'b0);
      run_until_issue(0, LUI_X5_ALIAS5, 0, s);
      check("lui_no_stall", s, 32'd0);

      // Back-to-back loads of x9 reload the countdown.
      drain();
      step(lw(9, 2), 1'b1, 1'b0, 1'b0);
      step(lw(9, 3), 1'b1, 1'b0, 1'b0);
      check("lat2_reload_mask", m1, 32'h0000_0200);
      run_until_issue(1, add(6, 9, 9), 0, s);
      check("lat2_reload_stalls", s, 32'd2);

      // Flush suppresses stall and issue; countdown keeps running.
      drain();
      step(lw(9, 2), 1'b1, 1'b0, 1'b0);
      step(add(6, 9, 9), 1'b1, 1'b1, 1'b0);
      check("flush_haz", {31'b0, obs_haz[1]}, 32'd0);
      check("flush_issue", {31'b0, obs_iss[1]}, 32'd0);
      run_until_issue(1, add(6, 9, 9), 0, s);
      check("flush_stalls", s, 32'd1);

      // Out-of-range registers on the 16-register build are untracked.
      drain();
      step(lw(20, 2), 1'b1, 1'b0, 1'b0);
      check("nr16_mask", mask_w[3], 32'h0);
      run_until_issue(3, add(6, 20, 20), 0, s);
      check("nr16_no_stall", s, 32'd0);

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
      check("perf_directed_lat1", sc0, 32'(stall_m[0]));
      check_perf();
`endif

      // Reset mid-flight wipes the pending load.
      drain();
      step(lw(9, 2), 1'b1, 1'b0, 1'b0);
      check("pre_rst_mask", m2, 32'h0000_0200);
      do_reset();
      run_until_issue(2, add(6, 9, 9), 0, s);
      check("post_rst_no_stall", s, 32'd0);

      // Random traffic against the model, with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] inst;
         logic [4:0]  rd, r1, r2;
         logic [6:0]  op;
         rd = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(14, 21)) : 5'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(14, 21)) : 5'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(14, 21)) : 5'($urandom_range(0, 7));
         op = ($urandom_range(0, 10) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         inst = {7'($urandom), r2, r1, 3'($urandom), rd, op};
         step(inst, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3);
         if (i % 400 == 399) begin
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
            check_perf();
`endif
            do_reset();
         end
      end

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
      check_perf();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
